// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, ALU op codes,
// divider state encoding and the decoded ID->EXE bus layout.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 140;
  localparam int ES_TO_MS_BUS_WD = 71;

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_SLT  = 4'd2;
  localparam logic [3:0] ALU_OP_SLTU = 4'd3;
  localparam logic [3:0] ALU_OP_AND  = 4'd4;
  localparam logic [3:0] ALU_OP_OR   = 4'd5;
  localparam logic [3:0] ALU_OP_NOR  = 4'd6;
  localparam logic [3:0] ALU_OP_XOR  = 4'd7;
  localparam logic [3:0] ALU_OP_SLL  = 4'd8;
  localparam logic [3:0] ALU_OP_SRL  = 4'd9;
  localparam logic [3:0] ALU_OP_SRA  = 4'd10;
  localparam logic [3:0] ALU_OP_LUI  = 4'd11;
  localparam logic [3:0] ALU_OP_DIV  = 4'd12;
  localparam logic [3:0] ALU_OP_DIVU = 4'd13;
  localparam logic [3:0] ALU_OP_MOD  = 4'd14;
  localparam logic [3:0] ALU_OP_MODU = 4'd15;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] rkd_value;
    logic        gr_we;
    logic [4:0]  dest;
    logic        mem_we;
    logic        res_from_mem;
  } ds_to_es_t;

  // The four divide ops occupy codes 12..15.
  function automatic logic is_div_op(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// sign correction applied on the held result.
module div_unit
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        ack,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [31:0] dsr_q, dsr_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;

  logic [32:0] rem_sh;
  logic        take;
  logic [31:0] abs1, abs2;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;

    abs1   = (is_signed && src1[31]) ? -src1 : src1;
    abs2   = (is_signed && src2[31]) ? -src2 : src2;
    rem_sh = {rem_q, dvd_q[31]};
    take   = rem_sh >= {1'b0, dsr_q};

    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d = DIV_BUSY;
          cnt_d   = 5'd0;
          rem_d   = 32'd0;
          dvd_d   = abs1;
          dsr_d   = abs2;
          q_neg_d = is_signed && (src1[31] ^ src2[31]);
          r_neg_d = is_signed && src1[31];
        end
      end
      DIV_BUSY: begin
        rem_d = take ? 32'(rem_sh - {1'b0, dsr_q}) : rem_sh[31:0];
        dvd_d = {dvd_q[30:0], take};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (ack) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= DIV_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: datapath registers carry no reset; the FSM guarantees they are written before use.
  always_ff @(posedge clk) begin
    cnt_q   <= cnt_d;
    rem_q   <= rem_d;
    dvd_q   <= dvd_d;
    dsr_q   <= dsr_d;
    q_neg_q <= q_neg_d;
    r_neg_q <= r_neg_d;
  end

  assign done      = (state_q == DIV_DONE);
  assign quotient  = q_neg_q ? -dvd_q : dvd_q;
  assign remainder = r_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: inline ALU plus iterative divider, data-SRAM request,
// EXE->MEM handoff and hazard/forwarding taps back to ID.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_allowin,
  input  logic                       ms_allowin,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [4:0]                 es_to_ds_dest,
  output logic                       es_is_load,
  output logic [31:0]                es_fwd_data,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  logic      es_valid_q, es_valid_d;
  ds_to_es_t es_bus_q, es_bus_d;

  logic        es_ready_go;
  logic        is_div;
  logic        div_done;
  logic [31:0] div_quo, div_rem;
  logic [31:0] alu_result, es_result;
  logic [31:0] src1, src2;

  assign src1   = es_bus_q.alu_src1;
  assign src2   = es_bus_q.alu_src2;
  assign is_div = is_div_op(es_bus_q.alu_op);

  div_unit u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (es_valid_q && is_div),
    .is_signed (es_bus_q.alu_op == ALU_OP_DIV || es_bus_q.alu_op == ALU_OP_MOD),
    .src1      (src1),
    .src2      (src2),
    .ack       (ms_allowin),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    alu_result = 32'd0;
    case (es_bus_q.alu_op)
      ALU_OP_ADD:  alu_result = src1 + src2;
      ALU_OP_SUB:  alu_result = src1 - src2;
      ALU_OP_SLT:  alu_result = {31'd0, $signed(src1) < $signed(src2)};
      ALU_OP_SLTU: alu_result = {31'd0, src1 < src2};
      ALU_OP_AND:  alu_result = src1 & src2;
      ALU_OP_OR:   alu_result = src1 | src2;
      ALU_OP_NOR:  alu_result = ~(src1 | src2);
      ALU_OP_XOR:  alu_result = src1 ^ src2;
      ALU_OP_SLL:  alu_result = src1 << src2[4:0];
      ALU_OP_SRL:  alu_result = src1 >> src2[4:0];
      ALU_OP_SRA:  alu_result = 32'($signed(src1) >>> src2[4:0]);
      ALU_OP_LUI:  alu_result = src2;
      default:     alu_result = 32'd0;
    endcase
  end

  // Remainder ops (codes 14 and 15) have bit 1 set within the divide group.
  assign es_result = is_div ? (es_bus_q.alu_op[1] ? div_rem : div_quo) : alu_result;

  always_comb begin
    es_ready_go    = is_div ? div_done : 1'b1;
    es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
    es_to_ms_valid = es_valid_q && es_ready_go;
    es_valid_d     = es_allowin ? ds_to_es_valid : es_valid_q;
    es_bus_d       = (ds_to_es_valid && es_allowin) ? ds_to_es_t'(ds_to_es_bus) : es_bus_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) es_valid_q <= 1'b0;
    else         es_valid_q <= es_valid_d;
  end

  always_ff @(posedge clk) begin
    es_bus_q <= es_bus_d;
  end

  assign es_to_ms_bus = {es_bus_q.pc, es_bus_q.gr_we, es_bus_q.dest,
                         es_result, es_bus_q.res_from_mem};

  assign es_to_ds_dest = es_valid_q ? es_bus_q.dest : 5'd0;
  assign es_is_load    = es_valid_q && es_bus_q.res_from_mem;
  assign es_fwd_data   = es_result;

  assign data_sram_en    = es_valid_q && es_ready_go && ms_allowin &&
                           (es_bus_q.mem_we || es_bus_q.res_from_mem);
  assign data_sram_we    = {4{es_bus_q.mem_we && data_sram_en}};
  assign data_sram_addr  = es_result;
  assign data_sram_wdata = es_bus_q.rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: occupancy/age model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ds_to_es_valid;
  logic [139:0] ds_to_es_bus;
  logic         es_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [4:0]   es_to_ds_dest;
  logic         es_is_load;
  logic [31:0]  es_fwd_data;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  exe_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_allowin      (es_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_to_ds_dest   (es_to_ds_dest),
    .es_is_load      (es_is_load),
    .es_fwd_data     (es_fwd_data),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic check_en = 1'b0;
  logic [31:0] pc_ctr = 32'h1c00_0000;

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the op definitions.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    logic        sgn, sa, sb;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return ~(a | b);
      4'd7:  return a ^ b;
      4'd8:  return a << b[4:0];
      4'd9:  return a >> b[4:0];
      4'd10: return 32'($signed(a) >>> b[4:0]);
      4'd11: return b;
      default: begin
        sgn = (op == 4'd12) || (op == 4'd14);
        sa  = sgn && a[31];
        sb  = sgn && b[31];
        ma  = sa ? -a : a;
        mb  = sb ? -b : b;
        if (mb == 32'd0) begin
          q = 32'hFFFF_FFFF;
          r = ma;
        end else begin
          q = ma / mb;
          r = ma % mb;
        end
        if (op[1]) return sa ? -r : r;
        return (sa ^ sb) ? -q : q;
      end
    endcase
  endfunction

  // Model: which instruction sits in EXE and how many cycles it has been there.
  logic      m_valid;
  ds_to_es_t m_ins;
  int        m_age;
  logic      m_ready;

  assign m_ready = m_valid && (!is_div_op(m_ins.alu_op) || m_age >= 33);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid <= 1'b0;
      m_age   <= 0;
    end else if (!m_valid || (m_ready && ms_allowin)) begin
      m_valid <= ds_to_es_valid;
      m_age   <= 0;
      if (ds_to_es_valid) m_ins <= ds_to_es_t'(ds_to_es_bus);
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic [31:0] exp_res;
      logic        exp_en;
      exp_res = ref_result(m_ins.alu_op, m_ins.alu_src1, m_ins.alu_src2);
      exp_en  = m_ready && ms_allowin && (m_ins.mem_we || m_ins.res_from_mem);
      check("es_allowin", es_allowin, !m_valid || (m_ready && ms_allowin));
      check("es_to_ms_valid", es_to_ms_valid, m_ready);
      check("data_sram_en", data_sram_en, exp_en);
      check("data_sram_we", data_sram_we, {4{exp_en && m_ins.mem_we}});
      check("es_to_ds_dest", es_to_ds_dest, m_valid ? m_ins.dest : 5'd0);
      check("es_is_load", es_is_load, m_valid && m_ins.res_from_mem);
      if (m_ready)
        check("es_to_ms_bus", es_to_ms_bus,
              {m_ins.pc, m_ins.gr_we, m_ins.dest, exp_res, m_ins.res_from_mem});
      if (m_valid && !is_div_op(m_ins.alu_op))
        check("es_fwd_data", es_fwd_data, exp_res);
      if (exp_en) begin
        check("data_sram_addr", data_sram_addr, exp_res);
        check("data_sram_wdata", data_sram_wdata, m_ins.rkd_value);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge (cycle E).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] rkd, input logic [4:0] dest,
                       input logic mem_we, input logic rfm);
    ds_to_es_t ins;
    ins.pc           = pc_ctr;
    ins.alu_op       = op;
    ins.alu_src1     = a;
    ins.alu_src2     = b;
    ins.rkd_value    = rkd;
    ins.gr_we        = !mem_we;
    ins.dest         = dest;
    ins.mem_we       = mem_we;
    ins.res_from_mem = rfm;
    pc_ctr           = pc_ctr + 32'd4;
    ds_to_es_bus     = ins;
    ds_to_es_valid   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (es_allowin) begin
        @(posedge clk);
        #1;
        ds_to_es_valid = 1'b0;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL issue_timeout: got no es_allowin expected acceptance within 100 cycles");
    ds_to_es_valid = 1'b0;
  endtask

  // Counts negedges from cycle E until the handoff and checks the result.
  task automatic wait_handoff(input string name, input logic [31:0] exp, output int cyc);
    cyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (es_to_ms_valid && ms_allowin) begin
        cyc = i;
        check(name, es_to_ms_bus[32:1], exp);
        break;
      end
    end
    if (cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no handoff expected one within 60 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  v_op  [12];
  logic [31:0] v_a   [12];
  logic [31:0] v_b   [12];
  logic [31:0] v_exp [12];

  initial begin
    int cyc;
    resetn         = 1'b0;
    ms_allowin     = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;

    v_op[0]  = ALU_OP_SUB;  v_a[0]  = 32'd10;        v_b[0]  = 32'd3;         v_exp[0]  = 32'd7;
    v_op[1]  = ALU_OP_SLT;  v_a[1]  = 32'hFFFF_FFFF; v_b[1]  = 32'd1;         v_exp[1]  = 32'd1;
    v_op[2]  = ALU_OP_SLTU; v_a[2]  = 32'hFFFF_FFFF; v_b[2]  = 32'd1;         v_exp[2]  = 32'd0;
    v_op[3]  = ALU_OP_AND;  v_a[3]  = 32'h0000_F0F0; v_b[3]  = 32'h0000_FF00; v_exp[3]  = 32'h0000_F000;
    v_op[4]  = ALU_OP_OR;   v_a[4]  = 32'h0000_F0F0; v_b[4]  = 32'h0000_0F0F; v_exp[4]  = 32'h0000_FFFF;
    v_op[5]  = ALU_OP_NOR;  v_a[5]  = 32'd0;         v_b[5]  = 32'd0;         v_exp[5]  = 32'hFFFF_FFFF;
    v_op[6]  = ALU_OP_XOR;  v_a[6]  = 32'hAAAA_5555; v_b[6]  = 32'hFFFF_0000; v_exp[6]  = 32'h5555_5555;
    v_op[7]  = ALU_OP_SLL;  v_a[7]  = 32'd1;         v_b[7]  = 32'h0000_003F; v_exp[7]  = 32'h8000_0000;
    v_op[8]  = ALU_OP_SRL;  v_a[8]  = 32'h8000_0000; v_b[8]  = 32'd4;         v_exp[8]  = 32'h0800_0000;
    v_op[9]  = ALU_OP_SRA;  v_a[9]  = 32'h8000_0000; v_b[9]  = 32'd4;         v_exp[9]  = 32'hF800_0000;
    v_op[10] = ALU_OP_LUI;  v_a[10] = 32'hDEAD_BEEF; v_b[10] = 32'h1234_5000; v_exp[10] = 32'h1234_5000;
    v_op[11] = ALU_OP_ADD;  v_a[11] = 32'hFFFF_FFFF; v_b[11] = 32'd2;         v_exp[11] = 32'd1;

    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    @(negedge clk);
    check("reset_allowin", es_allowin, 1'b1);
    check("reset_to_ms_valid", es_to_ms_valid, 1'b0);
    check("reset_sram_en", data_sram_en, 1'b0);
    check("reset_sram_we", data_sram_we, 4'h0);
    check("reset_dest", es_to_ds_dest, 5'd0);
    check("reset_is_load", es_is_load, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // ADD 5+7
    issue(ALU_OP_ADD, 32'd5, 32'd7, 32'd0, 5'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("add_valid", es_to_ms_valid, 1'b1);
    check("add_result", es_to_ms_bus[32:1], 32'd12);
    check("add_allowin", es_allowin, 1'b1);
    @(posedge clk);
    #1;

    // Load 0x1000+4
    issue(ALU_OP_ADD, 32'h1000, 32'd4, 32'd0, 5'd5, 1'b0, 1'b1);
    @(negedge clk);
    check("load_en", data_sram_en, 1'b1);
    check("load_we", data_sram_we, 4'h0);
    check("load_addr", data_sram_addr, 32'h1004);
    check("load_is_load", es_is_load, 1'b1);
    @(posedge clk);
    #1;

    // Store
    issue(ALU_OP_ADD, 32'h2000, 32'd8, 32'hCAFE_BABE, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("store_we", data_sram_we, 4'hF);
    check("store_addr", data_sram_addr, 32'h2008);
    check("store_wdata", data_sram_wdata, 32'hCAFE_BABE);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      issue(v_op[i], v_a[i], v_b[i], 32'd0, 5'(i + 1), 1'b0, 1'b0);
      wait_handoff("alu_vec", v_exp[i], cyc);
      check("alu_vec_latency", cyc, 0);
    end

    // Back-to-back single-cycle ops, model-checked
    for (int i = 0; i < 6; i++)
      issue(ALU_OP_ADD, 32'(i * 3), 32'(i + 100), 32'd0, 5'(i + 7), 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Divide corner cases
    issue(ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd9, 1'b0, 1'b0);
    wait_handoff("div_m7_2", 32'hFFFF_FFFD, cyc);
    check("div_latency", cyc, 33);
    issue(ALU_OP_MOD, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd9, 1'b0, 1'b0);
    wait_handoff("mod_m7_2", 32'hFFFF_FFFF, cyc);
    issue(ALU_OP_DIVU, 32'd9, 32'd0, 32'd0, 5'd9, 1'b0, 1'b0);
    wait_handoff("divu_9_0", 32'hFFFF_FFFF, cyc);
    issue(ALU_OP_MODU, 32'd9, 32'd0, 32'd0, 5'd9, 1'b0, 1'b0);
    wait_handoff("modu_9_0", 32'd9, cyc);
    issue(ALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd9, 1'b0, 1'b0);
    wait_handoff("div_intmin", 32'h8000_0000, cyc);
    issue(ALU_OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd9, 1'b0, 1'b0);
    wait_handoff("mod_intmin", 32'd0, cyc);

    // Back-to-back divides
    issue(ALU_OP_DIV, 32'd100, 32'd7, 32'd0, 5'd10, 1'b0, 1'b0);
    issue(ALU_OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'd0, 5'd11, 1'b0, 1'b0);
    wait_handoff("divu_b2b", 32'h0FFF_FFFF, cyc);
    check("divu_b2b_latency", cyc, 33);

    // MEM stall while DONE
    ms_allowin = 1'b0;
    issue(ALU_OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'd0, 5'd12, 1'b0, 1'b0);
    for (int i = 0; i < 38; i++) begin
      @(negedge clk);
      if (i >= 33) begin
        check("stall_valid", es_to_ms_valid, 1'b1);
        check("stall_result", es_to_ms_bus[32:1], 32'hFFFF_FFF2);
      end
    end
    @(posedge clk);
    #1;
    ms_allowin = 1'b1;
    wait_handoff("stall_release", 32'hFFFF_FFF2, cyc);
    check("stall_release_latency", cyc, 0);
    @(negedge clk);
    check("single_handoff", es_to_ms_valid, 1'b0);
    @(posedge clk);
    #1;
    issue(ALU_OP_DIVU, 32'd50, 32'd5, 32'd0, 5'd13, 1'b0, 1'b0);
    wait_handoff("divu_after_stall", 32'd10, cyc);
    check("divu_after_stall_latency", cyc, 33);

    // Reset in the middle of a divide (cnt = 10 in cycle E+11)
    issue(ALU_OP_DIV, 32'd1000, 32'd3, 32'd0, 5'd14, 1'b0, 1'b0);
    repeat (11) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_to_ms_valid", es_to_ms_valid, 1'b0);
    check("midrst_sram_en", data_sram_en, 1'b0);
    check("midrst_allowin", es_allowin, 1'b1);
    check("midrst_dest", es_to_ds_dest, 5'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    issue(ALU_OP_ADD, 32'd1, 32'd2, 32'd0, 5'd15, 1'b0, 1'b0);
    wait_handoff("add_after_reset", 32'd3, cyc);
    check("add_after_reset_latency", cyc, 0);
    issue(ALU_OP_DIV, 32'd1000, 32'd3, 32'd0, 5'd16, 1'b0, 1'b0);
    wait_handoff("div_after_reset", 32'd333, cyc);
    check("div_after_reset_latency", cyc, 33);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected completion before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage in-order pipeline, between decode (ID) and memory (MEM). It takes one decoded instruction per handshake and computes the ALU result or runs an iterative 32-cycle divide. It issues the data-SRAM request for loads and stores, then hands pc, writeback controls and result to MEM. It also reports its destination register, load status and result to ID for hazard detection and forwarding.

## Interface
- No parameters. Bus widths and ALU op codes live in the shared package.
- `clk`  in  1  pipeline clock.
- `resetn`  in  1  reset, asynchronous and active-low.
- `ds_to_es_valid`  in  1  ID holds a valid instruction.
- `ds_to_es_bus`  in  140  MSB→LSB fields: `pc`[32], `alu_op`[4], `alu_src1`[32], `alu_src2`[32], `rkd_value`[32], `gr_we`[1], `dest`[5], `mem_we`[1], `res_from_mem`[1].
- `es_allowin`  out  1  EXE accepts from ID this cycle.
- `ms_allowin`  in  1  MEM accepts from EXE this cycle.
- `es_to_ms_valid`  out  1  EXE result ready for MEM.
- `es_to_ms_bus`  out  71  fields: {`pc`[70:39], `gr_we`[38], `dest`[37:33], `es_result`[32:1], `res_from_mem`[0]}.
- `es_to_ds_dest`  out  5  destination register, forced to 0 when EXE is empty.
- `es_is_load`  out  1  `es_valid && res_from_mem`; drives ID load-use stall.
- `es_fwd_data`  out  32  `es_result`, for ID forwarding.
- `data_sram_en`  out  1  data SRAM request enable.
- `data_sram_we`  out  4  byte write enables.
- `data_sram_addr`  out  32  data SRAM address.
- `data_sram_wdata`  out  32  store data.

## Operation
- Handshake:
  - `es_allowin = !es_valid || (es_ready_go && ms_allowin)`.
  - `es_to_ms_valid = es_valid && es_ready_go`.
  - On a clock edge with `es_allowin` high, `es_valid` loads `ds_to_es_valid`.
  - The bus register loads only when `ds_to_es_valid && es_allowin`.
- Reset:
  - `es_valid` = 0; divider FSM = IDLE.
  - Resulting outputs: `es_to_ms_valid`, `data_sram_en`, `data_sram_we`, `es_to_ds_dest` and `es_is_load` all 0; `es_allowin` = 1.
  - Bus, address and data outputs are don't-care while invalid.
- ALU ops (4-bit `alu_op`):
  - ADD 0, SUB 1, SLT 2 (signed), SLTU 3, AND 4, OR 5, NOR 6, XOR 7.
  - SLL 8, SRL 9, SRA 10: shift amount is `alu_src2[4:0]`.
  - LUI 11: result = `alu_src2`; ID supplies the pre-shifted immediate.
  - DIV 12, DIVU 13, MOD 14, MODU 15.
  - All arithmetic is 32-bit modulo; SLT and SLTU produce 0 or 1.
- `es_ready_go` is 1 for non-divide ops and 1 only in divider state DONE for divide ops.
- Divider FSM (`div_unit`):
  - IDLE → BUSY when `es_valid` and the op is a divide. On this transition, latch operand magnitudes (absolute value for signed ops), result signs and `cnt = 0`.
  - BUSY: one restoring step per cycle on a 33-bit partial remainder. After the step with `cnt == 31`, go to DONE.
  - DONE: hold the result. Return to IDLE on the edge where `ms_allowin` is high (handoff).
- Divider sign and corner-case rules:
  - Quotient sign = s1^s2; remainder sign = s1.
  - x/0 yields magnitude quotient 0xFFFFFFFF and remainder |x|, then sign correction.
  - INT_MIN/−1 yields quotient 0x80000000, remainder 0.
- Memory request:
  - `data_sram_en = es_valid && es_ready_go && ms_allowin && (mem_we || res_from_mem)`.
  - `data_sram_we = {4{mem_we && data_sram_en}}`.
  - Address = `es_result`; `wdata` = `rkd_value`; word access only.

## Timing
- Non-divide op: 1 cycle in EXE if `ms_allowin` is high; the SRAM request and handoff occur in the same cycle.
- Divide op, entering EXE in cycle E:
  - E = IDLE, E+1..E+32 = BUSY, E+33 = DONE with `es_ready_go` = 1.
  - Handoff at the end of E+33 if `ms_allowin` is high.
- MEM stall while in DONE: the result holds and no recompute happens.
- Back-to-back divides: the second starts its IDLE cycle on the cycle after the first hands off.
- `es_allowin` stays low for the whole divide, so ID holds its instruction.
- Reset mid-divide: the FSM drops to IDLE immediately (asynchronous); no partial result escapes.
- `es_to_ds_dest`, `es_is_load` and `es_fwd_data` are combinational from EXE registers. They stay asserted through stall cycles.

## Structure
- Shared package holds:
  - bus widths `DS_TO_ES_BUS_WD` = 140 and `ES_TO_MS_BUS_WD` = 71;
  - the sixteen `ALU_OP_*` constants;
  - divider state encoding (IDLE, BUSY, DONE).
- Sub-module `div_unit` holds the iterative signed/unsigned divider.
  - Inputs: start, signed, operands, ack.
  - Outputs: `done`, quotient, remainder.
- The ALU proper stays inline.

## Test plan
- ADD 5+7 with `ms_allowin` = 1 → one cycle later `es_to_ms_bus[32:1]` = 12 and `es_allowin` stays high.
- Load with `alu_src1` = 0x1000, `alu_src2` = 4 → `data_sram_en` = 1, `we` = 0, `addr` = 0x1004, `es_is_load` = 1 in the handoff cycle.
- DIV −7/2 → `es_ready_go` rises exactly 33 cycles after entry with result 0xFFFFFFFD; MOD gives 0xFFFFFFFF.
- DIVU 9/0 → 0xFFFFFFFF; MODU 9/0 → 9; DIV 0x80000000/−1 → 0x80000000.
- Divide in DONE with `ms_allowin` held low for 5 cycles → result and `es_to_ms_valid` stable, single handoff, FSM back to IDLE.
- Assert `resetn` low at BUSY `cnt` = 10 → `es_valid` = 0 and `data_sram_en` = 0 at once; a fresh ADD after release completes normally.
